// File: rtl/fetch_align_if.sv
// fetch_align_if: req_* request handshake, fetch_* packet handshake and flush_* redirect bundle; master drives requests, slave is the splitter
interface fetch_align_if #(
  parameter int NUM_FETCH = 4,
  parameter int WID_W = 3
);
  localparam int NUM_W = $clog2(NUM_FETCH) + 1;
  logic req_valid;
  logic req_ready;
  logic [31:0] req_pc;
  logic [NUM_W-1:0] req_num;
  logic [WID_W-1:0] req_wid;
  logic fetch_valid;
  logic fetch_ready;
  logic [31:0] fetch_addr;
  logic [NUM_FETCH-1:0] fetch_mask;
  logic [WID_W-1:0] fetch_wid;
  logic fetch_last;
  logic fetch_misalign;
  logic flush_valid;
  logic [WID_W-1:0] flush_wid;
  modport master (
    output req_valid, req_pc, req_num, req_wid, fetch_ready, flush_valid, flush_wid,
    input req_ready, fetch_valid, fetch_addr, fetch_mask, fetch_wid, fetch_last, fetch_misalign
  );
  modport slave (
    input req_valid, req_pc, req_num, req_wid, fetch_ready, flush_valid, flush_wid,
    output req_ready, fetch_valid, fetch_addr, fetch_mask, fetch_wid, fetch_last, fetch_misalign
  );
endinterface

// File: rtl/fetch_align_splitter.sv
// fetch_align_splitter: splits a fetch request into one or two block-aligned masked packets; ports clk, rst, bus (fetch_align_if.slave: req_*, fetch_*, flush_*)
module fetch_align_splitter #(
  parameter int NUM_FETCH = 4,
  parameter int INST_BYTES = 4,
  parameter int WID_W = 3
) (
  input logic clk,
  input logic rst,
  fetch_align_if.slave bus
);
  localparam int ALIGN = NUM_FETCH * INST_BYTES;
  localparam int NUM_W = $clog2(NUM_FETCH) + 1;
  typedef enum logic [1:0] {IDLE, HOLD1, HOLD2} state_t;
  state_t state, state_nx;
  logic [31:0] pc_n, base, addr2_r;
  logic [NUM_W-1:0] num_n;
  logic [32:0] end_a;
  logic [NUM_FETCH-1:0] mask1, mask2, mask2_r;
  logic split, fire, accept, flush_hit;
  always_comb begin
    pc_n = bus.req_pc & ~32'(INST_BYTES - 1);
    num_n = (bus.req_num == '0 || bus.req_num > NUM_W'(NUM_FETCH)) ? NUM_W'(NUM_FETCH) : bus.req_num;
    base = pc_n & ~32'(ALIGN - 1);
    end_a = {1'b0, pc_n} + 33'(num_n) * 33'(INST_BYTES);
    split = end_a > {1'b0, base} + 33'(ALIGN);
    mask1 = '0;
    mask2 = '0;
    for (int i = 0; i < NUM_FETCH; i++) begin
      mask1[i] = ({1'b0, base} + 33'(i * INST_BYTES) >= {1'b0, pc_n}) && ({1'b0, base} + 33'(i * INST_BYTES) < end_a);
      mask2[i] = {1'b0, base} + 33'(ALIGN + i * INST_BYTES) < end_a;
    end
  end
  assign fire = bus.fetch_valid & bus.fetch_ready;
  assign accept = bus.req_valid & bus.req_ready;
  assign flush_hit = bus.flush_valid && state != IDLE && bus.flush_wid == bus.fetch_wid;
  assign bus.req_ready = state == IDLE || (fire && bus.fetch_last);
  assign bus.fetch_valid = state != IDLE;
  always_comb begin
    state_nx = accept ? HOLD1 : flush_hit ? IDLE : !fire ? state : bus.fetch_last ? IDLE : HOLD2;
  end
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.fetch_addr <= '0;
      bus.fetch_mask <= '0;
      bus.fetch_wid <= '0;
      bus.fetch_last <= 1'b0;
      bus.fetch_misalign <= 1'b0;
      addr2_r <= '0;
      mask2_r <= '0;
    end else if (accept) begin
      bus.fetch_addr <= base;
      bus.fetch_mask <= mask1;
      bus.fetch_wid <= bus.req_wid;
      bus.fetch_last <= !split;
      bus.fetch_misalign <= |(bus.req_pc & 32'(INST_BYTES - 1));
      addr2_r <= base + 32'(ALIGN);
      mask2_r <= mask2;
    end else if (fire && !bus.fetch_last && !flush_hit) begin
      bus.fetch_addr <= addr2_r;
      bus.fetch_mask <= mask2_r;
      bus.fetch_last <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_align_splitter.sv
// tb_fetch_align_splitter: directed stimulus with a scoreboard queue checked by a decoupled output monitor
module tb_fetch_align_splitter;
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0] mask;
    logic [2:0] wid;
    logic last;
    logic mis;
  } pkt_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int beats = 0;
  pkt_t sb[$];
  pkt_t mon_e;
  fetch_align_if #(.NUM_FETCH(4), .WID_W(3)) bus ();
  fetch_align_splitter #(.NUM_FETCH(4), .INST_BYTES(4), .WID_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic pkt_t pk(input logic [31:0] addr, input logic [3:0] mask, input logic [2:0] wid, input logic last, input logic mis);
    return {addr, mask, wid, last, mis};
  endfunction
  function automatic pkt_t cur();
    return {bus.fetch_addr, bus.fetch_mask, bus.fetch_wid, bus.fetch_last, bus.fetch_misalign};
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && bus.fetch_valid && bus.fetch_ready && !(bus.flush_valid && bus.flush_wid == bus.fetch_wid)) begin
      beats++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got %h expected none", cur());
      end else begin
        mon_e = sb.pop_front();
        chk("beat {addr,mask,wid,last,mis}", 64'(cur()), 64'(mon_e));
      end
    end
  end
  task automatic send(input logic [31:0] pc, input logic [2:0] num, input logic [2:0] wid, output int waits);
    waits = 0;
    bus.req_valid = 1'b1;
    bus.req_pc = pc;
    bus.req_num = num;
    bus.req_wid = wid;
    while (!bus.req_ready && waits < 100) begin
      @(posedge clk);
      #1;
      waits++;
    end
    if (waits >= 100) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got no req_ready expected req_ready within 100 cycles");
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int w;
    int b0;
    bus.req_valid = 1'b0;
    bus.req_pc = '0;
    bus.req_num = '0;
    bus.req_wid = '0;
    bus.fetch_ready = 1'b0;
    bus.flush_valid = 1'b0;
    bus.flush_wid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("rst_valid", bus.fetch_valid, 0);
    chk("rst_fields", 64'(cur()), 0);
    chk("rst_req_ready", bus.req_ready, 1);
    sb.push_back(pk(32'h20, 4'b0110, 3'd5, 1'b1, 1'b0));
    send(32'h24, 3'd2, 3'd5, w);
    chk("t1_valid", bus.fetch_valid, 1);
    chk("t1_fields", 64'(cur()), 64'(pk(32'h20, 4'b0110, 3'd5, 1'b1, 1'b0)));
    chk("t1_req_ready_stalled", bus.req_ready, 0);
    bus.fetch_ready = 1'b1;
    step();
    chk("t1_idle", bus.fetch_valid, 0);
    sb.push_back(pk(32'h10, 4'b1000, 3'd1, 1'b0, 1'b0));
    sb.push_back(pk(32'h20, 4'b0111, 3'd1, 1'b1, 1'b0));
    send(32'h1C, 3'd4, 3'd1, w);
    chk("t2_req_ready_beat1", bus.req_ready, 0);
    chk("t2_last_beat1", bus.fetch_last, 0);
    step();
    chk("t2_last_beat2", bus.fetch_last, 1);
    step();
    chk("t2_idle", bus.fetch_valid, 0);
    sb.push_back(pk(32'hFFFFFFF0, 4'b1100, 3'd0, 1'b0, 1'b0));
    sb.push_back(pk(32'h00000000, 4'b0011, 3'd0, 1'b1, 1'b0));
    send(32'hFFFFFFF8, 3'd4, 3'd0, w);
    repeat (2) step();
    chk("t3_idle", bus.fetch_valid, 0);
    sb.push_back(pk(32'h10, 4'b1000, 3'd2, 1'b0, 1'b0));
    send(32'h1C, 3'd4, 3'd2, w);
    step();
    chk("t4_hold2_addr", bus.fetch_addr, 32'h20);
    bus.flush_valid = 1'b1;
    bus.flush_wid = 3'd2;
    step();
    bus.flush_valid = 1'b0;
    chk("t4_flushed_valid", bus.fetch_valid, 0);
    step();
    chk("t4_no_second", bus.fetch_valid, 0);
    sb.push_back(pk(32'h10, 4'b1000, 3'd2, 1'b0, 1'b0));
    sb.push_back(pk(32'h20, 4'b0111, 3'd2, 1'b1, 1'b0));
    send(32'h1C, 3'd4, 3'd2, w);
    step();
    bus.flush_valid = 1'b1;
    bus.flush_wid = 3'd3;
    step();
    bus.flush_valid = 1'b0;
    chk("t4_other_wid_done", bus.fetch_valid, 0);
    sb.push_back(pk(32'h50, 4'b0001, 3'd4, 1'b1, 1'b0));
    send(32'h40, 3'd1, 3'd4, w);
    bus.flush_valid = 1'b1;
    bus.flush_wid = 3'd4;
    send(32'h50, 3'd1, 3'd4, w);
    bus.flush_valid = 1'b0;
    chk("t4_accept_survives_flush", bus.fetch_valid, 1);
    chk("t4_accept_addr", bus.fetch_addr, 32'h50);
    step();
    bus.fetch_ready = 1'b0;
    sb.push_back(pk(32'h10, 4'b1111, 3'd6, 1'b1, 1'b1));
    send(32'h13, 3'd0, 3'd6, w);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t5_stable_%0d", i), 64'(cur()), 64'(pk(32'h10, 4'b1111, 3'd6, 1'b1, 1'b1)));
      chk($sformatf("t5_valid_%0d", i), bus.fetch_valid, 1);
      step();
    end
    bus.fetch_ready = 1'b1;
    step();
    chk("t5_idle", bus.fetch_valid, 0);
    b0 = beats;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] m;
      m = 4'((1 << (i + 1)) - 1);
      sb.push_back(pk(32'h100, m, 3'(i), 1'b1, 1'b0));
      send(32'h100, 3'(i + 1), 3'(i), w);
      if (i > 0) chk($sformatf("t6_b2b_wait_%0d", i), w, 0);
    end
    step();
    chk("t6_beats", beats - b0, 4);
    repeat (3) step();
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_align_splitter.md
Name: fetch_align_splitter

Overview:
- Parametrised successor to the warp scheduler's combinational PC aligner.
- Accepts one fetch request per handshake: warp id, PC, and instruction count.
- Emits one or two I-cache-block-aligned fetch packets, each with a two-sided valid-slot mask. A request whose span crosses a block boundary is split over two output beats.
- Sits between the warp scheduler PC select and the I-cache request port. Supports per-warp flush on branch redirect.

Parameters:
- NUM_FETCH, 4, instruction slots per fetch block; power of 2, 2..16.
- INST_BYTES, 4, bytes per instruction; power of 2.
- WID_W, 3, warp-id width (NUM_WARP = 8).
- Derived: ALIGN = NUM_FETCH*INST_BYTES; NUM_W = $clog2(NUM_FETCH)+1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_pc  in  32  start PC.
- req_num  in  NUM_W  instructions wanted.
- req_wid  in  WID_W  warp id.
- fetch_valid  out  1  packet present.
- fetch_ready  in  1  downstream accepts packet.
- fetch_addr  out  32  ALIGN-aligned block address.
- fetch_mask  out  NUM_FETCH  slot i valid.
- fetch_wid  out  WID_W  warp id of packet.
- fetch_last  out  1  final packet of the request.
- fetch_misalign  out  1  req_pc[log2(INST_BYTES)-1:0] != 0.
- flush_valid  in  1  redirect for flush_wid.
- flush_wid  in  WID_W  warp being redirected.

Behaviour:
- Reset values: all outputs 0; state = IDLE. Synchronous reset: a held packet or pending split is discarded on the rst cycle.
- Normalisation:
  - pc_n = req_pc with low log2(INST_BYTES) bits cleared.
  - num_n = NUM_FETCH if req_num == 0 or req_num > NUM_FETCH; otherwise num_n = req_num.
  - base = pc_n & ~(ALIGN-1).
  - end = {1'b0,pc_n} + num_n*INST_BYTES, computed at 33 bits.
- First packet: fetch_addr = base. Mask bit i = (base+i*INST_BYTES >= pc_n) && ({1'b0,base}+i*INST_BYTES < end).
- Split: split = end > {1'b0,base}+ALIGN.
  - Second packet address = base+ALIGN, modulo 2^32; wraps to 0.
  - Second packet mask bit i = ({1'b0,base}+ALIGN+i*INST_BYTES < end).
  - fetch_last = 0 on the first packet and 1 on the second. fetch_last = 1 on a non-split single packet.
- States:
  - IDLE: output empty.
  - HOLD1: first or only packet held.
  - HOLD2: second packet held.
- Transitions:
  - IDLE --accept--> HOLD1.
  - HOLD1 --fire & last--> IDLE, or HOLD1 again if a new request is accepted the same cycle.
  - HOLD1 --fire & !last--> HOLD2.
  - HOLD2 --fire--> IDLE, or HOLD1 on a same-cycle accept.
- Handshake:
  - req_ready = (state == IDLE) || (fetch_valid & fetch_ready & fetch_last).
  - Output is registered: an accepted request appears on fetch_* the next cycle.
  - The second packet appears the cycle after the first fires. Throughput is 1 packet/cycle.
  - fetch_* fields are stable while fetch_valid & !fetch_ready.
- fetch_misalign is captured with the request and carried on both packets. It is informational; the masks still use pc_n.
- Flush:
  - flush_valid with flush_wid == held wid (HOLD1 or HOLD2) drops the packet and any pending second. Next state is IDLE and fetch_valid is 0 next cycle, even if fetch_ready was high in that cycle.
  - A request accepted in the same cycle as a flush is not flushed, whatever its wid.
  - A flush for a non-matching wid has no effect.
- No combinational path from fetch_ready to fetch_* data. req_ready may depend combinationally on fetch_ready.

Test Plan:
- rst high 2 cycles, then release with req_valid=0 -> all outputs 0, req_ready=1.
- req_pc=0x24, num=2, wid=5 -> next cycle: addr 0x20, mask 4'b0110, last=1, wid=5, misalign=0.
- req_pc=0x1C, num=4, fetch_ready=1 -> beat 1: addr 0x10, mask 4'b1000, last=0; beat 2: addr 0x20, mask 4'b0111, last=1; req_ready=0 during beat 1.
- req_pc=0xFFFFFFF8, num=4 -> addr 0xFFFFFFF0 mask 4'b1100, then addr 0x00000000 mask 4'b0011, last=1.
- Split request wid=2, first beat fires, flush_valid with flush_wid=2 in the HOLD2 cycle -> fetch_valid=0 next cycle, no second beat. Repeat with flush_wid=3 -> second beat delivered.
- req_num=0, pc=0x13 -> misalign=1, addr 0x10, mask 4'b1111, last=1. Also: fetch_ready held 0 for 5 cycles -> fields stable throughout. Back-to-back single requests with fetch_ready=1 -> one packet every cycle.
